// File: rtl/enabled_delay_line.sv
// DEPTH-stage enabled delay line for audio samples with a selectable registered tap, fill tracking and flush.
// Latency: b/b_last/valid are registered from the next-state line (same edge as the shift); full is combinational.
// No backpressure: enable is a one-per-sample strobe; DELAY_LINE_MIX_EN adds a saturating a + tap/2 mix output.
`timescale 1ns/1ps

module enabled_delay_line #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int TAPW  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic [WIDTH-1:0] a,
    input  logic [TAPW-1:0]  tap_sel,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] b_last,
    output logic             valid,
    output logic             full,
    output logic [TAPW:0]    fill_count
`ifdef DELAY_LINE_MIX_EN
    ,
    output logic [WIDTH-1:0] mix
`endif
);

    localparam logic [TAPW:0] DEPTH_C = (TAPW+1)'(DEPTH);
    localparam logic [TAPW:0] LAST_C  = (TAPW+1)'(DEPTH - 1);
    localparam logic [TAPW:0] ONE_C   = (TAPW+1)'(1);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];
    logic [TAPW:0]    fill_q;
    logic [TAPW:0]    fill_d;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] b_d;
    logic [WIDTH-1:0] b_last_q;
    logic [WIDTH-1:0] b_last_d;
    logic             valid_q;
    logic             valid_d;

    logic [TAPW:0]    tap_ext;
    logic [TAPW:0]    tap_eff;
    logic [WIDTH-1:0] tap_next;

    // Out-of-range taps read the oldest stage.
    always_comb begin
        tap_ext = {1'b0, tap_sel};
        tap_eff = (tap_ext >= DEPTH_C) ? LAST_C : tap_ext;
    end

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            stage_d[k] = stage_q[k];
        end
        fill_d = fill_q;
        if (clear) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_d[k] = '0;
            end
            fill_d = '0;
        end else if (enable) begin
            stage_d[0] = a;
            for (int k = 1; k < DEPTH; k++) begin
                stage_d[k] = stage_q[k-1];
            end
            if (fill_q != DEPTH_C) begin
                fill_d = fill_q + ONE_C;
            end
        end
    end

    // The registered tap follows the post-shift line so b lines up with the edge that moved it.
    always_comb begin
        tap_next = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (tap_eff == (TAPW+1)'(k)) begin
                tap_next = stage_d[k];
            end
        end
        b_d      = tap_next;
        b_last_d = stage_d[DEPTH-1];
        valid_d  = (fill_d > tap_eff);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_q[k] <= '0;
            end
            fill_q   <= '0;
            b_q      <= '0;
            b_last_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_q[k] <= stage_d[k];
            end
            fill_q   <= fill_d;
            b_q      <= b_d;
            b_last_q <= b_last_d;
            valid_q  <= valid_d;
        end
    end

`ifdef DELAY_LINE_MIX_EN
    logic [WIDTH-1:0] mix_q;
    logic [WIDTH-1:0] mix_d;
    logic [WIDTH-1:0] tap_cur;
    logic [WIDTH-1:0] tap_half;
    logic [WIDTH:0]   mix_sum;

    // Mix uses the pre-shift tap; an unfilled tap contributes nothing.
    always_comb begin
        tap_cur = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (tap_eff == (TAPW+1)'(k)) begin
                tap_cur = stage_q[k];
            end
        end
        tap_half = (fill_q > tap_eff) ? {tap_cur[WIDTH-1], tap_cur[WIDTH-1:1]} : '0;
        mix_sum  = {a[WIDTH-1], a} + {tap_half[WIDTH-1], tap_half};
    end

    always_comb begin
        mix_d = mix_q;
        if (clear) begin
            mix_d = '0;
        end else if (enable) begin
            if (mix_sum[WIDTH] != mix_sum[WIDTH-1]) begin
                mix_d = mix_sum[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
            end else begin
                mix_d = mix_sum[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mix_q <= '0;
        end else begin
            mix_q <= mix_d;
        end
    end

    assign mix = mix_q;
`endif

    assign b          = b_q;
    assign b_last     = b_last_q;
    assign valid      = valid_q;
    assign full       = (fill_q == DEPTH_C);
    assign fill_count = fill_q;

endmodule

// File: tb/tb_enabled_delay_line.sv
// Randomised bench for enabled_delay_line against a queue-based model of the delay line.
`timescale 1ns/1ps

module tb_enabled_delay_line;

    localparam int WIDTH = 16;
    localparam int DEPTH = 8;
    localparam int TAPW  = 4;

    logic             clk;
    logic             reset;
    logic             enable;
    logic             clear;
    logic [WIDTH-1:0] a;
    logic [TAPW-1:0]  tap_sel;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] b_last;
    logic             valid;
    logic             full;
    logic [TAPW:0]    fill_count;
`ifdef DELAY_LINE_MIX_EN
    logic [WIDTH-1:0] mix;
`endif

    int checks;
    int errors;

    logic [WIDTH-1:0] hist[$];
    logic [WIDTH-1:0] m_b;
    logic [WIDTH-1:0] m_last;
    logic [WIDTH-1:0] m_mix;
    logic             m_valid;
    logic             m_full;
    int               m_fill;

    enabled_delay_line #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAPW(TAPW)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .clear      (clear),
        .a          (a),
        .tap_sel    (tap_sel),
        .b          (b),
        .b_last     (b_last),
        .valid      (valid),
        .full       (full),
        .fill_count (fill_count)
`ifdef DELAY_LINE_MIX_EN
        ,
        .mix        (mix)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        hist.delete();
        m_b = '0; m_last = '0; m_mix = '0; m_valid = 1'b0; m_full = 1'b0; m_fill = 0;
    endtask

    // Model: hist holds the samples seen since the last clear, oldest first, capped at DEPTH.
    task automatic model_edge(input logic en, input logic clr, input logic [WIDTH-1:0] av,
                              input logic [TAPW-1:0] tp);
        int t, n, s;
        logic [WIDTH-1:0] tv;
        t = (int'(tp) >= DEPTH) ? DEPTH - 1 : int'(tp);
        if (clr) begin
            hist.delete();
            m_mix = '0;
        end else if (en) begin
            n  = hist.size();
            tv = (n > t) ? hist[n-1-t] : '0;
            s  = int'($signed(av)) + (int'($signed(tv)) >>> 1);
            if (s > 32767) s = 32767;
            if (s < -32768) s = -32768;
            m_mix = s[WIDTH-1:0];
            hist.push_back(av);
            if (hist.size() > DEPTH) void'(hist.pop_front());
        end
        n       = hist.size();
        m_fill  = n;
        m_b     = (n > t) ? hist[n-1-t] : '0;
        m_last  = (n == DEPTH) ? hist[0] : '0;
        m_valid = (n > t);
        m_full  = (n == DEPTH);
    endtask

    task automatic tick(input logic en, input logic clr, input logic [WIDTH-1:0] av,
                        input logic [TAPW-1:0] tp);
        enable = en; clear = clr; a = av; tap_sel = tp;
        @(posedge clk);
        model_edge(en, clr, av, tp);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; clear = 1'b0; a = '0; tap_sel = '0;
        model_reset();
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 16'(i + 100), 4'd0);
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({b, b_last, valid, full, fill_count} !== '0) begin
            errors++;
            $display("FAIL reset_async b=%h b_last=%h valid=%b full=%b fill=%0d required all 0",
                     b, b_last, valid, full, fill_count);
        end
        @(posedge clk); #1;
        checks++;
        if ({b, b_last, valid, full, fill_count} !== '0) begin
            errors++;
            $display("FAIL reset_held b=%h b_last=%h valid=%b full=%b fill=%0d required all 0",
                     b, b_last, valid, full, fill_count);
        end
        #2 reset = 1'b1;
        model_reset();
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 10; i++) begin
            tick(1'b1, 1'b0, 16'(i), 4'd2);
            checks++;
            if (b !== m_b || b_last !== m_last || valid !== m_valid || full !== m_full ||
                int'(fill_count) !== m_fill) begin
                errors++;
                $display("FAIL fill_%0d got b=%h last=%h v=%b f=%b n=%0d required b=%h last=%h v=%b f=%b n=%0d",
                         i, b, b_last, valid, full, fill_count, m_b, m_last, m_valid, m_full, m_fill);
            end
            if (i == 3) begin
                checks++;
                if (valid !== 1'b1 || b !== 16'd1) begin
                    errors++;
                    $display("FAIL fill_third_valid got v=%b b=%h required v=1 b=0001", valid, b);
                end
            end
            if (i == 8) begin
                checks++;
                if (full !== 1'b1 || b_last !== 16'd1 || fill_count !== 5'd8) begin
                    errors++;
                    $display("FAIL fill_eighth got full=%b b_last=%h n=%0d required 1 0001 8",
                             full, b_last, fill_count);
                end
            end
        end
        checks++;
        if (fill_count !== 5'd8) begin
            errors++;
            $display("FAIL fill_saturate got %0d required 8", fill_count);
        end
    endtask

    task automatic test_enable_gaps();
        logic [TAPW-1:0] tp;
        tp = 4'($urandom_range(0, 9));
        tick(1'b0, 1'b1, '0, tp);
        for (int i = 0; i < 48; i++) begin
            tick((i % 4) == 3, 1'b0, 16'($urandom), tp);
            checks++;
            if (b !== m_b || b_last !== m_last || valid !== m_valid || int'(fill_count) !== m_fill) begin
                errors++;
                $display("FAIL gaps_%0d got b=%h last=%h v=%b n=%0d required b=%h last=%h v=%b n=%0d",
                         i, b, b_last, valid, fill_count, m_b, m_last, m_valid, m_fill);
            end
        end
    endtask

    task automatic test_clear_priority();
        for (int i = 0; i < DEPTH; i++) tick(1'b1, 1'b0, 16'($urandom), 4'd0);
        tick(1'b1, 1'b1, 16'hBEEF, 4'd0);
        checks++;
        if (fill_count !== 5'd0 || b !== 16'd0 || valid !== 1'b0 || full !== 1'b0 || b_last !== 16'd0) begin
            errors++;
            $display("FAIL clear_priority got n=%0d b=%h v=%b f=%b last=%h required all 0",
                     fill_count, b, valid, full, b_last);
        end
        tick(1'b1, 1'b0, 16'h1234, 4'd0);
        checks++;
        if (b !== 16'h1234 || fill_count !== 5'd1 || valid !== 1'b1) begin
            errors++;
            $display("FAIL clear_refill got b=%h n=%0d v=%b required 1234 1 1", b, fill_count, valid);
        end
    endtask

    task automatic test_tap_clamp();
        tick(1'b0, 1'b1, '0, 4'd0);
        for (int i = 1; i <= DEPTH; i++) tick(1'b1, 1'b0, 16'(i), 4'd0);
        tick(1'b0, 1'b0, '0, 4'd0);
        checks++;
        if (b !== 16'd8) begin
            errors++;
            $display("FAIL tap0 got b=%h required 0008", b);
        end
        tap_sel = 4'd7;
        #2;
        checks++;
        if (b !== 16'd8) begin
            errors++;
            $display("FAIL tap_before_edge got b=%h required 0008", b);
        end
        tick(1'b0, 1'b0, '0, 4'd7);
        checks++;
        if (b !== 16'd1) begin
            errors++;
            $display("FAIL tap7 got b=%h required 0001", b);
        end
        tick(1'b0, 1'b0, '0, 4'd0);
        tick(1'b0, 1'b0, '0, 4'd12);
        checks++;
        if (b !== 16'd1 || valid !== 1'b1) begin
            errors++;
            $display("FAIL tap_clamp got b=%h v=%b required 0001 1", b, valid);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            tick(($urandom % 3) != 0, ($urandom % 29) == 0, 16'($urandom), 4'($urandom));
            checks++;
            if (b !== m_b || b_last !== m_last || valid !== m_valid || full !== m_full ||
                int'(fill_count) !== m_fill) begin
                errors++;
                $display("FAIL random_%0d got b=%h last=%h v=%b f=%b n=%0d required b=%h last=%h v=%b f=%b n=%0d",
                         i, b, b_last, valid, full, fill_count, m_b, m_last, m_valid, m_full, m_fill);
            end
`ifdef DELAY_LINE_MIX_EN
            checks++;
            if (mix !== m_mix) begin
                errors++;
                $display("FAIL random_mix_%0d got %h required %h", i, mix, m_mix);
            end
`endif
        end
    endtask

    task automatic test_async_mid_shift();
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 16'($urandom | 1), 4'd0);
        enable = 1'b1;
        #3 reset = 1'b0;
        #1;
        checks++;
        if ({b, b_last, valid, full, fill_count} !== '0) begin
            errors++;
            $display("FAIL async_mid_shift b=%h last=%h v=%b f=%b n=%0d required all 0",
                     b, b_last, valid, full, fill_count);
        end
`ifdef DELAY_LINE_MIX_EN
        checks++;
        if (mix !== '0) begin
            errors++;
            $display("FAIL async_mix got %h required 0000", mix);
        end
`endif
        @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

`ifdef DELAY_LINE_MIX_EN
    task automatic test_mix_saturation();
        tick(1'b0, 1'b1, '0, 4'd0);
        tick(1'b1, 1'b0, 16'h7FFE, 4'd0);
        checks++;
        if (mix !== 16'h7FFE) begin
            errors++;
            $display("FAIL mix_invalid_tap got %h required 7ffe", mix);
        end
        tick(1'b1, 1'b0, 16'h7000, 4'd0);
        checks++;
        if (mix !== 16'h7FFF) begin
            errors++;
            $display("FAIL mix_pos_sat got %h required 7fff", mix);
        end
        tick(1'b0, 1'b0, 16'h0001, 4'd0);
        checks++;
        if (mix !== 16'h7FFF) begin
            errors++;
            $display("FAIL mix_hold got %h required 7fff", mix);
        end
        tick(1'b0, 1'b1, '0, 4'd0);
        checks++;
        if (mix !== 16'h0000) begin
            errors++;
            $display("FAIL mix_clear got %h required 0000", mix);
        end
        tick(1'b1, 1'b0, 16'h8000, 4'd0);
        tick(1'b1, 1'b0, 16'h8000, 4'd0);
        checks++;
        if (mix !== 16'h8000) begin
            errors++;
            $display("FAIL mix_neg_sat got %h required 8000", mix);
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_fill();
        test_enable_gaps();
        test_clear_priority();
        test_tap_clamp();
        test_random();
        test_async_mid_shift();
`ifdef DELAY_LINE_MIX_EN
        test_mix_saturation();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
